// File: rtl/snow64_mem_access_arbiter_pkg.sv
// Shared types for the Snow64 external-memory arbiter: widths, access types,
// arbiter state/requester enums and the port-bundle structs.
package PkgSnow64Cpu;

  localparam int unsigned MSB_POS__SNOW64_CPU_ADDR      = 63;
  localparam int unsigned MSB_POS__SNOW64_LAR_FILE_DATA = 255;

  typedef logic [MSB_POS__SNOW64_CPU_ADDR:0]      CpuAddr;
  typedef logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] LarData;

  typedef enum logic {
    ExtDataAccTypRead  = 1'b0,
    ExtDataAccTypWrite = 1'b1
  } ExtDataAccessType;

  typedef enum logic {
    StIdle    = 1'b0,
    StWaitMem = 1'b1
  } MemArbState;

  typedef enum logic {
    MemArbReqInst = 1'b0,
    MemArbReqData = 1'b1
  } MemArbRequester;

  typedef struct packed {
    logic             valid;
    LarData           data;
  } PartialPortIn_Cpu_ExtDataAccess;

  typedef struct packed {
    logic             req;
    ExtDataAccessType access_type;
    CpuAddr           addr;
    LarData           data;
  } PartialPortOut_Cpu_ExtDataAccess;

  typedef struct packed {
    logic             req;
    ExtDataAccessType access_type;
    CpuAddr           addr;
    LarData           data;
  } PartialPortIn_MemArb_Requester;

  typedef struct packed {
    logic             busy;
    logic             valid;
    LarData           data;
  } PartialPortOut_MemArb_Requester;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  function automatic MemArbRequester pick_requester(input logic           inst_avail,
                                                    input logic           data_avail,
                                                    input MemArbRequester last_served);
    if (inst_avail && data_avail)
      return (last_served == MemArbReqData) ? MemArbReqInst : MemArbReqData;
    else if (data_avail)
      return MemArbReqData;
    else
      return MemArbReqInst;
  endfunction

endpackage

// File: rtl/snow64_mem_access_arbiter_slot.sv
// One-entry request holding register for a single arbiter requester,
// with busy tracking and a view that already includes a same-cycle request.
module snow64_mem_arb_slot
  import PkgSnow64Cpu::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  PartialPortIn_MemArb_Requester in_req,
  input  logic                          clear,
  output logic                          busy,
  output PartialPortIn_MemArb_Requester view
);

  logic             load;
  ExtDataAccessType held_access_type;
  CpuAddr           held_addr;
  LarData           held_data;

  // Requests arriving while busy are dropped on purpose.
  assign load = in_req.req && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy             <= 1'b0;
      held_access_type <= ExtDataAccTypRead;
      held_addr        <= '0;
      held_data        <= '0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (load) begin
      busy             <= 1'b1;
      held_access_type <= in_req.access_type;
      held_addr        <= in_req.addr;
      held_data        <= in_req.data;
    end
  end

  // Bypass the incoming request so an idle arbiter can issue it immediately.
  always_comb begin
    view.req = busy || load;
    if (busy) begin
      view.access_type = held_access_type;
      view.addr        = held_addr;
      view.data        = held_data;
    end else begin
      view.access_type = in_req.access_type;
      view.addr        = in_req.addr;
      view.data        = in_req.data;
    end
  end

endmodule

// File: rtl/snow64_mem_access_arbiter.sv
// Round-robin arbiter sharing the single external memory port between
// instruction fetch and LAR-file data traffic, one transaction at a time.
module snow64_mem_access_arbiter
  import PkgSnow64Cpu::*;
(
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_inst_req,
  input  logic                                    in_data_req,
  input  ExtDataAccessType                        in_inst_access_type,
  input  ExtDataAccessType                        in_data_access_type,
  input  logic [MSB_POS__SNOW64_CPU_ADDR:0]       in_inst_addr,
  input  logic [MSB_POS__SNOW64_CPU_ADDR:0]       in_data_addr,
  input  logic [MSB_POS__SNOW64_LAR_FILE_DATA:0]  in_inst_data,
  input  logic [MSB_POS__SNOW64_LAR_FILE_DATA:0]  in_data_data,
  output logic                                    out_inst_busy,
  output logic                                    out_data_busy,
  output logic                                    out_inst_valid,
  output logic                                    out_data_valid,
  output logic [MSB_POS__SNOW64_LAR_FILE_DATA:0]  out_inst_data,
  output logic [MSB_POS__SNOW64_LAR_FILE_DATA:0]  out_data_data,
  input  PartialPortIn_Cpu_ExtDataAccess          in_ext,
  output PartialPortOut_Cpu_ExtDataAccess         out_ext
);

  MemArbState                    state;
  MemArbRequester                sel;
  MemArbRequester                last_served;
  MemArbRequester                winner;
  PartialPortIn_MemArb_Requester inst_in, data_in;
  PartialPortIn_MemArb_Requester inst_view, data_view, win_view;
  logic                          done;
  logic                          clear_inst, clear_data;

  assign inst_in = '{req: in_inst_req, access_type: in_inst_access_type,
                     addr: in_inst_addr, data: in_inst_data};
  assign data_in = '{req: in_data_req, access_type: in_data_access_type,
                     addr: in_data_addr, data: in_data_data};

  assign done       = (state == StWaitMem) && in_ext.valid;
  assign clear_inst = done && (sel == MemArbReqInst);
  assign clear_data = done && (sel == MemArbReqData);

  snow64_mem_arb_slot u_inst_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_req (inst_in),
    .clear  (clear_inst),
    .busy   (out_inst_busy),
    .view   (inst_view)
  );

  snow64_mem_arb_slot u_data_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_req (data_in),
    .clear  (clear_data),
    .busy   (out_data_busy),
    .view   (data_view)
  );

  assign winner   = pick_requester(inst_view.req, data_view.req, last_served);
  assign win_view = (winner == MemArbReqInst) ? inst_view : data_view;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StIdle;
      sel            <= MemArbReqInst;
      last_served    <= MemArbReqData;
      out_ext        <= '0;
      out_inst_valid <= 1'b0;
      out_data_valid <= 1'b0;
      out_inst_data  <= '0;
      out_data_data  <= '0;
    end else begin
      out_inst_valid <= 1'b0;
      out_data_valid <= 1'b0;
      out_ext.req    <= 1'b0;
      case (state)
        StIdle: begin
          if (inst_view.req || data_view.req) begin
            sel                 <= winner;
            out_ext.req         <= win_view.req;
            out_ext.access_type <= win_view.access_type;
            out_ext.addr        <= win_view.addr;
            out_ext.data        <= win_view.data;
            state               <= StWaitMem;
          end
        end
        StWaitMem: begin
          if (in_ext.valid) begin
            last_served <= sel;
            state       <= StIdle;
            if (sel == MemArbReqInst) begin
              out_inst_valid <= 1'b1;
              out_inst_data  <= in_ext.data;
            end else begin
              out_data_valid <= 1'b1;
              out_data_data  <= in_ext.data;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_mem_access_arbiter.sv
// Self-checking bench for snow64_mem_access_arbiter: vector table plus
// corner sequences, with a latency-programmable memory model and scoreboards.
module tb_snow64_mem_access_arbiter;
  import PkgSnow64Cpu::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inst_req = 1'b0, data_req = 1'b0;
  ExtDataAccessType inst_type = ExtDataAccTypRead, data_type = ExtDataAccTypRead;
  CpuAddr           inst_addr = '0, data_addr = '0;
  LarData           inst_wdata = '0, data_wdata = '0;
  logic             inst_busy, data_busy, inst_valid, data_valid;
  LarData           inst_rdata, data_rdata;
  PartialPortIn_Cpu_ExtDataAccess  ext_in;
  PartialPortOut_Cpu_ExtDataAccess ext_out;

  always #5 clk = ~clk;

  snow64_mem_access_arbiter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_inst_req         (inst_req),
    .in_data_req         (data_req),
    .in_inst_access_type (inst_type),
    .in_data_access_type (data_type),
    .in_inst_addr        (inst_addr),
    .in_data_addr        (data_addr),
    .in_inst_data        (inst_wdata),
    .in_data_data        (data_wdata),
    .out_inst_busy       (inst_busy),
    .out_data_busy       (data_busy),
    .out_inst_valid      (inst_valid),
    .out_data_valid      (data_valid),
    .out_inst_data       (inst_rdata),
    .out_data_data       (data_rdata),
    .in_ext              (ext_in),
    .out_ext             (ext_out)
  );

  typedef struct {
    ExtDataAccessType typ;
    CpuAddr           addr;
    LarData           wdata;
  } issue_t;

  typedef struct {
    bit     i_req;
    bit     i_wr;
    CpuAddr i_addr;
    bit     d_req;
    bit     d_wr;
    CpuAddr d_addr;
    int     lat;
  } vec_t;

  issue_t         exp_issue[$];
  LarData         exp_inst[$];
  LarData         exp_data[$];
  int unsigned    errors = 0;
  int unsigned    checks = 0;
  int unsigned    cyc = 0;
  int unsigned    mem_cnt = 0;
  int unsigned    mem_lat = 1;
  int unsigned    mem_valid_cyc = 0;
  int unsigned    stray_req = 0;
  MemArbRequester ls_model = MemArbReqData;

  function automatic LarData resp(input CpuAddr a);
    if (a == 64'h100) return {32{8'hAB}};
    return {4{a ^ 64'hC3C3_0000_5A5A_0000}};
  endfunction

  function automatic LarData wdata_of(input CpuAddr a);
    return {4{~a}};
  endfunction

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model and output monitor, sampled on the falling edge.
  initial begin
    issue_t      cur;
    bit          in_flight;
    int unsigned stray_seen;
    in_flight  = 1'b0;
    stray_seen = 0;
    ext_in     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_flight = 1'b0;
      end else begin
        if (inst_valid) begin
          if (exp_inst.size() == 0) chk("inst_valid_unexpected", 512'(inst_valid), 512'(0));
          else begin
            chk("inst_rdata", 512'(inst_rdata), 512'(exp_inst.pop_front()));
            chk("inst_valid_latency", 512'(cyc), 512'(mem_valid_cyc + 1));
          end
        end
        if (data_valid) begin
          if (exp_data.size() == 0) chk("data_valid_unexpected", 512'(data_valid), 512'(0));
          else begin
            chk("data_rdata", 512'(data_rdata), 512'(exp_data.pop_front()));
            chk("data_valid_latency", 512'(cyc), 512'(mem_valid_cyc + 1));
          end
        end
        if (in_flight)
          chk("ext_hold", 512'({ext_out.access_type, ext_out.addr}), 512'({cur.typ, cur.addr}));
      end
      ext_in.valid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          ext_in.valid  = 1'b1;
          ext_in.data   = resp(cur.addr);
          mem_valid_cyc = cyc;
          in_flight     = 1'b0;
        end
      end
      if (stray_seen != stray_req) begin
        stray_seen   = stray_req;
        ext_in.valid = 1'b1;
        ext_in.data  = '1;
      end
      if (rst_n && ext_out.req) begin
        if (exp_issue.size() == 0) chk("ext_req_unexpected", 512'(ext_out.req), 512'(0));
        else begin
          cur = exp_issue.pop_front();
          chk("ext_addr", 512'(ext_out.addr), 512'(cur.addr));
          chk("ext_type", 512'(ext_out.access_type), 512'(cur.typ));
          if (cur.typ == ExtDataAccTypWrite)
            chk("ext_wdata", 512'(ext_out.data), 512'(cur.wdata));
          in_flight = 1'b1;
          mem_cnt   = mem_lat;
        end
      end
    end
  end

  task automatic start(input bit ir, input bit iw, input CpuAddr ia,
                       input bit dr, input bit dw, input CpuAddr da);
    issue_t ii, dd;
    inst_req   = ir;
    inst_type  = iw ? ExtDataAccTypWrite : ExtDataAccTypRead;
    inst_addr  = ia;
    inst_wdata = wdata_of(ia);
    data_req   = dr;
    data_type  = dw ? ExtDataAccTypWrite : ExtDataAccTypRead;
    data_addr  = da;
    data_wdata = wdata_of(da);
    ii = '{typ: inst_type, addr: ia, wdata: wdata_of(ia)};
    dd = '{typ: data_type, addr: da, wdata: wdata_of(da)};
    if (ir && dr) begin
      if (ls_model == MemArbReqData) begin
        exp_issue.push_back(ii);
        exp_issue.push_back(dd);
        ls_model = MemArbReqData;
      end else begin
        exp_issue.push_back(dd);
        exp_issue.push_back(ii);
        ls_model = MemArbReqInst;
      end
    end else if (ir) begin
      exp_issue.push_back(ii);
      ls_model = MemArbReqInst;
    end else if (dr) begin
      exp_issue.push_back(dd);
      ls_model = MemArbReqData;
    end
    if (ir) exp_inst.push_back(resp(ia));
    if (dr) exp_data.push_back(resp(da));
  endtask

  task automatic release_reqs();
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  function automatic bit work_left();
    return exp_issue.size() != 0 || exp_inst.size() != 0 || exp_data.size() != 0 || mem_cnt != 0;
  endfunction

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (work_left() && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 512'(work_left()), 512'(0));
    repeat (3) tick();
    chk({name, "_idle_busy"}, 512'({inst_busy, data_busy}), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[7];
    int unsigned n;
    vecs[0] = '{1, 0, 64'h100,  0, 0, 64'h0,    3};
    vecs[1] = '{1, 0, 64'h10,   1, 1, 64'h20,   2};
    vecs[2] = '{1, 0, 64'h30,   1, 0, 64'h50,   1};
    vecs[3] = '{0, 0, 64'h0,    1, 1, 64'h60,   1};
    vecs[4] = '{1, 0, 64'hA0,   0, 0, 64'h0,    1};
    vecs[5] = '{1, 0, 64'hB0,   1, 0, 64'hC0,   2};
    vecs[6] = '{1, 1, 64'h1000, 1, 1, 64'h2000, 5};

    tick();
    tick();
    chk("rst_ext_out", 512'(ext_out), 512'(0));
    chk("rst_flags", 512'({inst_busy, data_busy, inst_valid, data_valid}), 512'(0));
    chk("rst_rdata", 512'({inst_rdata, data_rdata}), 512'(0));
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      mem_lat = vecs[i].lat;
      start(vecs[i].i_req, vecs[i].i_wr, vecs[i].i_addr,
            vecs[i].d_req, vecs[i].d_wr, vecs[i].d_addr);
      tick();
      chk($sformatf("vec%0d_ext_req", i), 512'(ext_out.req), 512'(1));
      chk($sformatf("vec%0d_busy", i), 512'({inst_busy, data_busy}),
          512'({vecs[i].i_req, vecs[i].d_req}));
      release_reqs();
      drain($sformatf("vec%0d", i));
    end

    // New request accepted in the same cycle as its own valid pulse.
    mem_lat = 2;
    start(1, 0, 64'hD0, 0, 0, 64'h0);
    tick();
    release_reqs();
    n = 0;
    while (!inst_valid && n < 50) begin
      tick();
      n++;
    end
    chk("b2b_valid_seen", 512'(inst_valid), 512'(1));
    start(1, 0, 64'hE0, 0, 0, 64'h0);
    tick();
    release_reqs();
    chk("b2b_ext_req", 512'(ext_out.req), 512'(1));
    chk("b2b_busy", 512'(inst_busy), 512'(1));
    drain("b2b");

    // Second request while busy is dropped.
    mem_lat = 4;
    start(0, 0, 64'h0, 1, 1, 64'h40);
    tick();
    release_reqs();
    tick();
    data_req  = 1'b1;
    data_addr = 64'h80;
    tick();
    data_req = 1'b0;
    chk("drop_busy", 512'(data_busy), 512'(1));
    drain("drop");

    // Reset in the middle of a transaction; late memory valid must be ignored.
    mem_lat = 6;
    start(1, 0, 64'h200, 0, 0, 64'h0);
    tick();
    release_reqs();
    tick();
    tick();
    rst_n = 1'b0;
    exp_inst.delete();
    ls_model = MemArbReqData;
    tick();
    chk("midrst_ext_out", 512'(ext_out), 512'(0));
    chk("midrst_flags", 512'({inst_busy, data_busy, inst_valid, data_valid}), 512'(0));
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("midrst_after_req", 512'(ext_out.req), 512'(0));
    chk("midrst_after_busy", 512'({inst_busy, data_busy}), 512'(0));
    mem_lat = 2;
    start(1, 0, 64'h300, 1, 0, 64'h400);
    tick();
    release_reqs();
    chk("midrst_tie_ext_addr", 512'(ext_out.addr), 512'(64'h300));
    drain("midrst_tie");

    // Stray memory valid while idle.
    stray_req++;
    repeat (3) tick();
    chk("stray_req", 512'(ext_out.req), 512'(0));
    chk("stray_busy", 512'({inst_busy, data_busy}), 512'(0));
    mem_lat = 1;
    start(1, 0, 64'h500, 0, 0, 64'h0);
    tick();
    release_reqs();
    chk("stray_next_ext_req", 512'(ext_out.req), 512'(1));
    drain("stray_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
